// File: rtl/lsu_bridge.sv
// rtl/lsu_bridge.sv - RV32 load/store to word-aligned bus bridge with byte enables and load extension.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two beats; otherwise they are rejected.
module lsu_bridge #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        WAIT0  = 3'd2
`ifdef LSU_MISALIGN_SPLIT_EN
        ,
        ISSUE1 = 3'd3,
        WAIT1  = 3'd4
`endif
    } state_t;

    state_t     state;
    logic [1:0] off_r;
    logic [1:0] size_r;
    logic       uns_r;

    logic [2:0] req_n;
    logic [3:0] req_mask;
    logic       req_mis;
    logic       req_bad;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] size,
                                                input logic uns);
        case (size)
            2'b00:   return uns ? {24'b0, w[7:0]} : {{24{w[7]}}, w[7:0]};
            2'b01:   return uns ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Request is held in reset as not-ready so nothing can be captured then.
    assign req_ready = (state == IDLE) && !resetn;

    always_comb begin
        req_mask = size_mask(req_funct3[1:0]);
        case (req_funct3[1:0])
            2'b00:   req_n = 3'd1;
            2'b01:   req_n = 3'd2;
            default: req_n = 3'd4;
        endcase
        req_mis = ({1'b0, req_addr[1:0]} + req_n) > 3'd4;
        req_bad = (req_funct3[1:0] == 2'b11) || (req_we && req_funct3[2]);
`ifndef LSU_MISALIGN_SPLIT_EN
        req_bad = req_bad || req_mis;
`endif
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        mis_r;
    logic [31:0] wdata_r;
    logic [31:0] rd0;
    logic [2:0]  beat1_sh;
    logic [31:0] merged;

    always_comb begin
        beat1_sh = 3'd4 - {1'b0, off_r};
        merged   = (rd0 >> {off_r, 3'b000}) | (bus_rdata << {beat1_sh, 3'b000});
    end
`endif

    always_ff @(posedge clk) begin
        if (resetn) begin
            state      <= IDLE;
            bus_valid  <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= 4'b0;
            bus_wdata  <= 32'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'b0;
            resp_err   <= 1'b0;
            off_r      <= 2'b0;
            size_r     <= 2'b0;
            uns_r      <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            mis_r      <= 1'b0;
            wdata_r    <= 32'b0;
            rd0        <= 32'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'b0;
            case (state)
                IDLE: if (req_valid) begin
                    off_r  <= req_addr[1:0];
                    size_r <= req_funct3[1:0];
                    uns_r  <= req_funct3[2];
                    if (req_bad) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        state     <= ISSUE0;
                        bus_valid <= 1'b1;
                        bus_we    <= req_we;
                        bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        bus_be    <= req_mask << req_addr[1:0];
                        bus_wdata <= req_wdata << {req_addr[1:0], 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
                        mis_r     <= req_mis;
                        wdata_r   <= req_wdata;
`endif
                    end
                end
                ISSUE0: if (bus_ready) begin
                    bus_valid <= 1'b0;
                    state     <= WAIT0;
                end
                WAIT0: if (bus_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (mis_r) begin
                        rd0       <= bus_rdata;
                        state     <= ISSUE1;
                        bus_valid <= 1'b1;
                        bus_addr  <= bus_addr + ADDR_W'(4);
                        bus_be    <= size_mask(size_r) >> beat1_sh;
                        bus_wdata <= wdata_r >> {beat1_sh, 3'b000};
                    end else
`endif
                    begin
                        state      <= IDLE;
                        resp_valid <= 1'b1;
                        resp_rdata <= bus_we ? 32'b0
                                    : load_extend(bus_rdata >> {off_r, 3'b000}, size_r, uns_r);
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ISSUE1: if (bus_ready) begin
                    bus_valid <= 1'b0;
                    state     <= WAIT1;
                end
                WAIT1: if (bus_rvalid) begin
                    state      <= IDLE;
                    resp_valid <= 1'b1;
                    resp_rdata <= bus_we ? 32'b0 : load_extend(merged, size_r, uns_r);
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bridge.sv
// tb/tb_lsu_bridge.sv - directed scoreboard bench for lsu_bridge.
module tb_lsu_bridge;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_funct3;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    lsu_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Response scoreboard: every response must match the oldest pending expectation.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                chk("resp_rdata", resp_rdata, e.rdata);
            end
        end
    end

    task automatic send_req(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3);
        int w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic bus_beat(input logic we, input logic [ADDR_W-1:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int stall);
        int w = 0;
        while (bus_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("beat_valid", {31'b0, bus_valid}, 32'd1);
        chk("beat_we", {31'b0, bus_we}, {31'b0, we});
        chk("beat_addr", {18'b0, bus_addr}, {18'b0, addr});
        chk("beat_be", {28'b0, bus_be}, {28'b0, be});
        if (we) chk("beat_wdata", bus_wdata, wdata);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, bus_valid}, 32'd1);
            chk("stall_addr", {18'b0, bus_addr}, {18'b0, addr});
            chk("stall_be", {28'b0, bus_be}, {28'b0, be});
        end
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        chk("wait_no_valid", {31'b0, bus_valid}, 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = rdata;
        @(negedge clk);
        bus_rvalid = 1'b0;
        bus_rdata  = 32'b0;
    endtask

    task automatic send_bad(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3);
        exp_q.push_back('{err: 1'b1, rdata: 32'b0});
        send_req(we, addr, wdata, f3);
        chk("bad_resp_timing", {31'b0, resp_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("bad_no_bus", {31'b0, bus_valid}, 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic load_one(input logic [ADDR_W-1:0] addr, input logic [2:0] f3,
                            input logic [3:0] be, input logic [31:0] rdata,
                            input logic [31:0] want);
        exp_q.push_back('{err: 1'b0, rdata: want});
        send_req(1'b0, addr, 32'b0, f3);
        bus_beat(1'b0, {addr[ADDR_W-1:2], 2'b00}, be, 32'b0, rdata, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = 32'b0;
        req_funct3 = 3'b0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_bus_valid", {31'b0, bus_valid}, 32'd0);
        chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
        chk("rst_bus_addr", {18'b0, bus_addr}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", {31'b0, req_ready}, 32'd1);

        // Store byte at 0x0005; bus_valid must appear the cycle after acceptance.
        exp_q.push_back('{err: 1'b0, rdata: 32'b0});
        send_req(1'b1, 14'h0005, 32'h000000AB, 3'b000);
        chk("latency_bus_valid", {31'b0, bus_valid}, 32'd1);
        bus_beat(1'b1, 14'h0004, 4'b0010, 32'h0000AB00, 32'hFFFFFFFF, 0);
        chk("latency_resp", {31'b0, resp_valid}, 32'd1);

        load_one(14'h0002, 3'b001, 4'b1100, 32'h80FF1234, 32'hFFFF80FF);
        load_one(14'h0002, 3'b101, 4'b1100, 32'h80FF1234, 32'h000080FF);
        load_one(14'h0007, 3'b000, 4'b1000, 32'hA5000000, 32'hFFFFFFA5);
        load_one(14'h0007, 3'b100, 4'b1000, 32'hA5000000, 32'h000000A5);
        load_one(14'h0010, 3'b010, 4'b1111, 32'h89ABCDEF, 32'h89ABCDEF);

`ifdef LSU_MISALIGN_SPLIT_EN
        exp_q.push_back('{err: 1'b0, rdata: 32'h66778811});
        send_req(1'b0, 14'h0003, 32'b0, 3'b010);
        bus_beat(1'b0, 14'h0000, 4'b1000, 32'b0, 32'h11223344, 0);
        bus_beat(1'b0, 14'h0004, 4'b0111, 32'b0, 32'h55667788, 0);

        exp_q.push_back('{err: 1'b0, rdata: 32'b0});
        send_req(1'b1, 14'h3FFE, 32'hDEADBEEF, 3'b010);
        bus_beat(1'b1, 14'h3FFC, 4'b1100, 32'hBEEF0000, 32'b0, 0);
        bus_beat(1'b1, 14'h0000, 4'b0011, 32'h0000DEAD, 32'b0, 0);
`else
        send_bad(1'b0, 14'h0003, 32'b0, 3'b010);
        send_bad(1'b1, 14'h3FFE, 32'hDEADBEEF, 3'b010);
`endif

        send_bad(1'b0, 14'h0008, 32'b0, 3'b011);
        send_bad(1'b1, 14'h0008, 32'h12345678, 3'b100);

        // Bus stalls for 5 cycles before accepting.
        exp_q.push_back('{err: 1'b0, rdata: 32'hCAFEF00D});
        send_req(1'b0, 14'h0100, 32'b0, 3'b010);
        bus_beat(1'b0, 14'h0100, 4'b1111, 32'b0, 32'hCAFEF00D, 5);

        // Reset while waiting for read data: the transaction disappears.
        send_req(1'b0, 14'h0020, 32'b0, 3'b010);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        chk("mid_wait_no_valid", {31'b0, bus_valid}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("mid_rst_bus_valid", {31'b0, bus_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("mid_rst_resp", {31'b0, resp_valid}, 32'd0);
        resetn = 1'b0;
        #1;
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h0BADBAD0;
        @(negedge clk);
        bus_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stray_no_resp", {31'b0, resp_valid}, 32'd0);
            chk("stray_no_bus", {31'b0, bus_valid}, 32'd0);
            @(negedge clk);
        end

        exp_q.push_back('{err: 1'b0, rdata: 32'b0});
        send_req(1'b1, 14'h3FFC, 32'h12345678, 3'b010);
        bus_beat(1'b1, 14'h3FFC, 4'b1111, 32'h12345678, 32'b0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
